// File: rtl/mem_arb_pkg.sv
// Shared defaults and width helpers for the round-robin memory arbiter.
package mem_arb_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int ADDR_W_DEF    = 7;
  localparam int DATA_W_DEF    = 8;
  localparam int LOCK_MAX_DEF  = 4;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int ptr_w(input int num_ports);
    return (num_ports < 2) ? 1 : $clog2(num_ports);
  endfunction

  // Lock counter must be able to represent LOCK_MAX itself.
  function automatic int cnt_w(input int lock_max);
    return $clog2(lock_max + 1);
  endfunction

endpackage

// File: rtl/mem_arb_rr.sv
// Combinational round-robin picker: first requester at or above ptr (modulo NUM_PORTS) wins.
module mem_arb_rr
  import mem_arb_pkg::*;
#(
  parameter int  NUM_PORTS = NUM_PORTS_DEF,
  localparam int PTR_W     = ptr_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [PTR_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [PTR_W-1:0]     gnt_idx
);

  logic             found;
  logic [PTR_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      idx = PTR_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[idx]) begin
        found      = 1'b1;
        gnt[idx]   = 1'b1;
        gnt_idx    = idx;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter in front of a single-port word memory with per-port registered read data.
// Optional grant locking is built when MEM_ARB_LOCK_EN is defined.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LOCK_MAX  = LOCK_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_PORTS-1:0]          req,
  input  logic [NUM_PORTS-1:0]          we,
  input  logic [NUM_PORTS-1:0]          lock,
  input  logic [NUM_PORTS*ADDR_W-1:0]   addr,
  input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
  output logic [NUM_PORTS-1:0]          gnt,
  output logic [NUM_PORTS-1:0]          rvalid,
  output logic [NUM_PORTS*DATA_W-1:0]   rdata
);

  localparam int PTR_W = ptr_w(NUM_PORTS);

  logic [PTR_W-1:0]            ptr;
  logic [PTR_W-1:0]            rr_idx;
  logic [PTR_W-1:0]            ptr_next;
  logic [NUM_PORTS-1:0]        rr_gnt;
  logic                        any_gnt;
  logic [ADDR_W-1:0]           sel_addr;
  logic [DATA_W-1:0]           sel_wdata;
  logic                        sel_we;
  logic [DATA_W-1:0]           mem [2**ADDR_W];
  logic [NUM_PORTS-1:0]        vld_p1;
  logic [NUM_PORTS*DATA_W-1:0] rdata_p1;

  mem_arb_rr #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_idx (rr_idx)
  );

  // Reset gates the grant combinationally so it drops the instant rst_n falls.
  assign gnt      = (rst_n && en) ? rr_gnt : '0;
  assign any_gnt  = |gnt;
  assign ptr_next = (rr_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : rr_idx + 1'b1;

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (rr_gnt[p]) begin
        sel_addr  = addr[p*ADDR_W +: ADDR_W];
        sel_wdata = wdata[p*DATA_W +: DATA_W];
        sel_we    = we[p];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (any_gnt && sel_we) begin
      mem[sel_addr] <= sel_wdata;
    end
  end

  // p0 -> p1: read data lands in the granted port's lane one cycle after the grant edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= '0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= '0;
      if (any_gnt && !sel_we) begin
        vld_p1 <= gnt;
        for (int p = 0; p < NUM_PORTS; p++) begin
          if (gnt[p]) begin
            rdata_p1[p*DATA_W +: DATA_W] <= mem[sel_addr];
          end
        end
      end
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = rdata_p1;

`ifdef MEM_ARB_LOCK_EN
  localparam int CNT_W = cnt_w(LOCK_MAX);

  logic [CNT_W-1:0] lock_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             hold;

  // A grant to a port other than the one parked at ptr starts a fresh run.
  always_comb begin
    cnt_next = (rr_idx == ptr) ? lock_cnt + 1'b1 : CNT_W'(1);
    hold     = lock[rr_idx] && (int'(cnt_next) < LOCK_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= '0;
      lock_cnt <= '0;
    end else if (any_gnt) begin
      if (hold) begin
        ptr      <= rr_idx;
        lock_cnt <= cnt_next;
      end else begin
        ptr      <= ptr_next;
        lock_cnt <= '0;
      end
    end
  end
`else
  logic          unused_lock;
  localparam int unused_lock_max = LOCK_MAX;

  assign unused_lock = ^lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (any_gnt) begin
      ptr <= ptr_next;
    end
  end
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_PORTS, 4, number of requesting ports (2..8).
REQ-002 Parameter ADDR_W, 7, word-address width; memory depth 2**ADDR_W.
REQ-003 Parameter DATA_W, 8, data word width.
REQ-004 Parameter LOCK_MAX, 4, maximum consecutive grants to one locked port (1..15).
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 en  in  1  global enable; low blocks new grants.
REQ-008 req  in  NUM_PORTS  per-port access request, held until granted.
REQ-009 we  in  NUM_PORTS  per-port write (1) / read (0) select.
REQ-010 lock  in  NUM_PORTS  per-port grant-hold request (MEM_ARB_LOCK_EN only).
REQ-011 addr  in  NUM_PORTS*ADDR_W  packed per-port addresses, port p at [p*ADDR_W +: ADDR_W].
REQ-012 wdata  in  NUM_PORTS*DATA_W  packed per-port write data.
REQ-013 gnt  out  NUM_PORTS  one-hot-or-zero grant, combinational from req, en, arbiter state.
REQ-014 rvalid  out  NUM_PORTS  one-cycle read-data-valid pulse per port.
REQ-015 rdata  out  NUM_PORTS*DATA_W  packed per-port read data, registered.

Function
REQ-016 Internal storage SHALL be a 2**ADDR_W x DATA_W single-port array; at most one access per cycle.
REQ-017 Access occurs on the rising edge where gnt[p]=1; write stores wdata[p] at addr[p]; read captures mem[addr[p]].
REQ-018 Read latency SHALL be one cycle: rvalid[p]=1 and rdata[p] valid in the cycle after the granting edge.
REQ-019 rdata[p] SHALL hold its last read value until the next read by port p; writes never update rdata.
REQ-020 Arbitration SHALL be round-robin: search starts at pointer ptr, first requesting port upward (mod NUM_PORTS) wins.
REQ-021 After a grant to port p (lock not held), ptr SHALL become (p+1) mod NUM_PORTS; no grant leaves ptr unchanged.
REQ-022 en=0: gnt SHALL be all-zero, ptr and lock counter unchanged; a read granted on the prior edge still delivers rvalid.
REQ-023 No req asserted: gnt all-zero, no memory access, ptr unchanged.
REQ-024 Address wrap-around SHALL not exist: addr indexes memory directly, all values legal.

Reset
REQ-025 rst_n low SHALL immediately force gnt=0, rvalid=0, rdata=0, ptr=0, lock counter=0.
REQ-026 Memory contents SHALL not be reset; an access in flight at reset is discarded (no rvalid after release).
REQ-027 First grant after reset release SHALL follow priority order starting at port 0.

Configuration
REQ-028 Macro MEM_ARB_LOCK_EN defined: granted port p with lock[p]=1 and req[p]=1 keeps ptr=p; grant count increments.
REQ-029 With MEM_ARB_LOCK_EN, after LOCK_MAX consecutive grants to p, ptr SHALL advance to p+1 regardless of lock; counter clears on any rotation.
REQ-030 MEM_ARB_LOCK_EN undefined: lock input ignored, no counter logic, pure round-robin.

Structure
REQ-031 Package mem_arb_pkg SHALL hold default parameter constants and the ptr/counter width functions.
REQ-032 Sub-module mem_arb_rr SHALL implement the combinational round-robin picker (req, ptr -> one-hot gnt).

Verification (NUM_PORTS=4, ADDR_W=7, DATA_W=8, LOCK_MAX=4)
REQ-033 Port0 write addr 10 data 8'd10, then port1 read addr 10 -> rvalid[1] one cycle after gnt[1], rdata1=8'd10.
REQ-034 req=4'b1111 held, en=1 -> gnt sequence 0001,0010,0100,1000,0001 on successive cycles.
REQ-035 req=4'b1111, en dropped after grant to port1 for 3 cycles -> gnt=0 during; first grant after en=1 is port2.
REQ-036 MEM_ARB_LOCK_EN, req=4'b1100, lock[2]=1 -> gnt[2] four consecutive cycles, then gnt[3].
REQ-037 Port3 read granted, rst_n pulsed low before next edge -> rvalid=0, rdata=0; first post-reset grant with req=4'b1010 goes to port1.
REQ-038 Only req[3]=1 continuously -> gnt[3]=1 every cycle, ptr cycles to 0 each grant.
